// File: rtl/iir_mac_accumulator_pkg.sv
// Shared types and constants for the IIR multiply-accumulate stage.
// Contents: datapath widths, tap count, saturation limits, FSM state enum,
//           sample/accumulator/tap-index types.
package iir_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned NUM_TAPS = 5;
  localparam int unsigned TAP_W    = 3;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} mac_state_t;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic [TAP_W-1:0]         tap_t;

endpackage

// File: rtl/iir_mac_accumulator_if.sv
// Product-in / sample-out bus of the IIR multiply-accumulate stage.
// master: upstream multiplier plus downstream consumer (drives products, y_ready).
// slave : the accumulator (drives prod_ready, tap_idx, busy, y_out/y_sat/y_valid).
interface iir_mac_accumulator_if
  import iir_pkg::*;
;
  sample_t prod_in;
  logic    prod_sub;
  logic    prod_valid;
  logic    prod_ready;
  tap_t    tap_idx;
  logic    busy;
  sample_t y_out;
  logic    y_sat;
  logic    y_valid;
  logic    y_ready;

  modport master (
    output prod_in, prod_sub, prod_valid, y_ready,
    input  prod_ready, tap_idx, busy, y_out, y_sat, y_valid
  );

  modport slave (
    input  prod_in, prod_sub, prod_valid, y_ready,
    output prod_ready, tap_idx, busy, y_out, y_sat, y_valid
  );

endinterface

// File: rtl/iir_mac_accumulator_acc_saturator.sv
// Combinational clamp of a wide signed sum to a narrower signed result.
// Ports: sum (IN_W signed) -> result_c (OUT_W, clamped), clipped_c (1 = clamped).
module acc_saturator
  import iir_pkg::*;
#(
  parameter int unsigned IN_W  = ACC_W,
  parameter int unsigned OUT_W = DATA_W
) (
  input  logic signed [IN_W-1:0] sum,
  output logic [OUT_W-1:0]       result_c,
  output logic                   clipped_c
);

  // Largest and smallest OUT_W-representable values, sign-extended to IN_W.
  localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    result_c  = sum[OUT_W-1:0];
    clipped_c = 1'b0;
    if (sum > HI) begin
      result_c  = {1'b0, {(OUT_W-1){1'b1}}};
      clipped_c = 1'b1;
    end else if (sum < LO) begin
      result_c  = {1'b1, {(OUT_W-1){1'b0}}};
      clipped_c = 1'b1;
    end
  end

endmodule

// File: rtl/iir_mac_accumulator.sv
// IIR multiply-accumulate stage: sums NUM_TAPS products per frame (feedback
// taps subtracted) and emits one saturated Q7.8 sample per frame.
// Ports: clk, rst_n (async active-low), bus (slave side of
//        iir_mac_accumulator_if: product handshake, tap_idx, busy, output handshake).
module iir_mac_accumulator
  import iir_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  iir_mac_accumulator_if.slave bus
);

  // Elaboration-time guards on the accumulator width and tap count.
  if (ACC_W < DATA_W + $clog2(NUM_TAPS) + 1) begin : g_acc_w_check
    $error("ACC_W too narrow for DATA_W and NUM_TAPS");
  end
  if (NUM_TAPS < 1 || NUM_TAPS > 8) begin : g_taps_check
    $error("NUM_TAPS must be in 1..8");
  end

  mac_state_t state_q, state_nxt;
  acc_t       acc_q, acc_d;
  tap_t       cnt_q, cnt_d;
  sample_t    y_out_q, y_out_d;
  logic       y_sat_q, y_sat_d;
  logic       y_valid_q, y_valid_d;
  logic       prod_ready_q, prod_ready_d;
  logic       busy_q, busy_d;

  logic    accept_c, last_c, out_hs_c;
  acc_t    term_c, sum_c;
  sample_t sat_y_c;
  logic    sat_clip_c;

  assign accept_c = bus.prod_valid && prod_ready_q;
  assign last_c   = (cnt_q == TAP_W'(NUM_TAPS - 1));
  assign out_hs_c = y_valid_q && bus.y_ready;

  // Sign-extend before negating so -(-32768) stays representable.
  assign term_c = bus.prod_sub ? -ACC_W'(bus.prod_in) : ACC_W'(bus.prod_in);
  // acc_q is zero in IDLE, so this also covers the first term of a frame.
  assign sum_c  = acc_q + term_c;

  acc_saturator #(
    .IN_W (ACC_W),
    .OUT_W(DATA_W)
  ) u_sat (
    .sum      (sum_c),
    .result_c (sat_y_c),
    .clipped_c(sat_clip_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (accept_c) state_nxt = last_c ? HOLD : ACCUM;
      HOLD:        if (out_hs_c) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    y_out_d      = y_out_q;
    y_sat_d      = y_sat_q;
    y_valid_d    = y_valid_q;
    prod_ready_d = (state_nxt != HOLD);
    busy_d       = (state_nxt != IDLE);
    if (accept_c) begin
      acc_d = sum_c;
      cnt_d = cnt_q + TAP_W'(1);
      if (last_c) begin
        y_out_d   = sat_y_c;
        y_sat_d   = sat_clip_c;
        y_valid_d = 1'b1;
      end
    end
    if (state_q == HOLD && out_hs_c) begin
      y_valid_d = 1'b0;
      cnt_d     = '0;
      acc_d     = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      y_out_q      <= '0;
      y_sat_q      <= 1'b0;
      y_valid_q    <= 1'b0;
      prod_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      y_out_q      <= y_out_d;
      y_sat_q      <= y_sat_d;
      y_valid_q    <= y_valid_d;
      prod_ready_q <= prod_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.tap_idx    = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.y_out      = y_out_q;
  assign bus.y_sat      = y_sat_q;
  assign bus.y_valid    = y_valid_q;

endmodule

// File: tb/tb_iir_mac_accumulator.sv
// Directed self-checking bench for iir_mac_accumulator.
module tb_iir_mac_accumulator;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  iir_mac_accumulator_if bus ();

  iir_mac_accumulator dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one product and return at the negedge after it was accepted.
  task automatic send(input logic [15:0] d, input logic s);
    int guard = 0;
    bus.prod_in    = d;
    bus.prod_sub   = s;
    bus.prod_valid = 1'b1;
    while (bus.prod_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready_wait", 16'(guard < 50), 16'd1);
    @(negedge clk);
  endtask

  // Release the held sample and check the return to IDLE.
  task automatic release_out(input logic [15:0] exp_y);
    bus.y_ready = 1'b1;
    @(negedge clk);
    bus.y_ready = 1'b0;
    chk("rel_y_valid", 16'(bus.y_valid), 16'd0);
    chk("rel_busy", 16'(bus.busy), 16'd0);
    chk("rel_tap_idx", 16'(bus.tap_idx), 16'd0);
    chk("rel_prod_ready", 16'(bus.prod_ready), 16'd1);
    chk("rel_y_keep", bus.y_out, exp_y);
  endtask

  // One frame: a first term followed by four identical terms.
  task automatic frame(input string tag, input logic [15:0] d0, input logic s0,
                       input logic [15:0] dn, input logic sn,
                       input logic [15:0] exp_y, input logic exp_sat);
    send(d0, s0);
    for (int i = 0; i < 4; i++) send(dn, sn);
    bus.prod_valid = 1'b0;
    chk({tag, "_y_valid"}, 16'(bus.y_valid), 16'd1);
    chk({tag, "_y_out"}, bus.y_out, exp_y);
    chk({tag, "_y_sat"}, 16'(bus.y_sat), 16'(exp_sat));
    release_out(exp_y);
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.prod_in    = '0;
    bus.prod_sub   = 1'b0;
    bus.prod_valid = 1'b0;
    bus.y_ready    = 1'b0;

    // Reset state.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_y_out", bus.y_out, 16'h0000);
    chk("rst_y_sat", 16'(bus.y_sat), 16'd0);
    chk("rst_y_valid", 16'(bus.y_valid), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_tap_idx", 16'(bus.tap_idx), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_prod_ready", 16'(bus.prod_ready), 16'd1);

    // Five 1.0 products with valid held high; watch tap_idx and latency.
    for (int i = 0; i < 5; i++) begin
      chk("f1_tap_idx", bus.tap_idx, 16'(i));
      chk("f1_y_valid_low", 16'(bus.y_valid), 16'd0);
      send(16'h0100, 1'b0);
      if (i == 0) chk("f1_busy", 16'(bus.busy), 16'd1);
    end
    bus.prod_valid = 1'b0;
    chk("f1_y_valid", 16'(bus.y_valid), 16'd1);
    chk("f1_y_out", bus.y_out, 16'h0500);
    chk("f1_y_sat", 16'(bus.y_sat), 16'd0);
    chk("f1_prod_ready", 16'(bus.prod_ready), 16'd0);
    release_out(16'h0500);

    // Feedback subtraction and saturation cases.
    frame("cancel", 16'h0200, 1'b0, 16'h0080, 1'b1, 16'h0000, 1'b0);
    frame("neg1",   16'h0100, 1'b0, 16'h0080, 1'b1, 16'hFF00, 1'b0);
    frame("posov",  16'h7000, 1'b0, 16'h7000, 1'b0, 16'h7FFF, 1'b1);
    frame("negov",  16'h9000, 1'b0, 16'h9000, 1'b0, 16'h8000, 1'b1);
    frame("negmin", 16'h8000, 1'b1, 16'h0000, 1'b0, 16'h7FFF, 1'b1);
    frame("edgehi", 16'h7FFF, 1'b0, 16'h0000, 1'b0, 16'h7FFF, 1'b0);
    frame("edgelo", 16'h8000, 1'b0, 16'h0000, 1'b0, 16'h8000, 1'b0);

    // Backpressure: products keep arriving while the result is held.
    send(16'h0100, 1'b0);
    for (int i = 0; i < 4; i++) send(16'h0100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_prod_ready", 16'(bus.prod_ready), 16'd0);
      chk("bp_y_valid", 16'(bus.y_valid), 16'd1);
      chk("bp_y_out", bus.y_out, 16'h0500);
      @(negedge clk);
    end
    bus.prod_valid = 1'b0;
    release_out(16'h0500);
    frame("bp_next", 16'h0100, 1'b0, 16'h0100, 1'b0, 16'h0500, 1'b0);

    // Valid gaps: tap_idx moves only on accepted beats.
    for (int i = 0; i < 5; i++) begin
      send(16'h0100, 1'b0);
      bus.prod_valid = 1'b0;
      if (i < 4) begin
        chk("gap_tap_acc", bus.tap_idx, 16'(i + 1));
        @(negedge clk);
        chk("gap_tap_idle", bus.tap_idx, 16'(i + 1));
      end
    end
    chk("gap_y_valid", 16'(bus.y_valid), 16'd1);
    chk("gap_y_out", bus.y_out, 16'h0500);
    release_out(16'h0500);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 3; i++) send(16'h0100, 1'b0);
    bus.prod_valid = 1'b0;
    chk("mid_busy", 16'(bus.busy), 16'd1);
    chk("mid_tap_idx", bus.tap_idx, 16'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_y_out", bus.y_out, 16'h0000);
    chk("mrst_y_valid", 16'(bus.y_valid), 16'd0);
    chk("mrst_busy", 16'(bus.busy), 16'd0);
    chk("mrst_tap_idx", bus.tap_idx, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame("post_rst", 16'h0100, 1'b0, 16'h0100, 1'b0, 16'h0500, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
